// File: rtl/rv64_multicycle_core.sv
// Multi-cycle RV64I subset core: FETCH -> EXEC (-> LOAD for LD), separate
// word-addressed program SRAM and doubleword-addressed data SRAM ports.
module rv64_multicycle_core (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [63:0] o_pm_addr,
    output logic        o_pm_cs,
    input  logic [31:0] i_pm_data,
    output logic [63:0] o_dm_addr,
    output logic        o_dm_cs,
    output logic        o_dm_rw,
    output logic [63:0] o_dm_data,
    input  logic [63:0] i_dm_data
);
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [63:0] regs_q [32];

    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [63:0] reg_wd;

    // Decode fields come straight from the SRAM output during EXEC.
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] rs1_val, rs2_val;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [63:0] ea_ld, ea_st;
    logic        imm_ok, alt_i, r_ok, take;

    assign instr   = i_pm_data;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1_val = regs_q[instr[19:15]];
    assign rs2_val = regs_q[instr[24:20]];
    assign imm_i   = {{52{instr[31]}}, instr[31:20]};
    assign imm_s   = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j   = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign ea_ld   = rs1_val + imm_i;
    assign ea_st   = rs1_val + imm_s;

    assign o_pm_addr = {2'b00, pc_q[63:2]};

    // Only rd of IR is needed after EXEC; the low EA bits are ignored by design.
    logic unused_ok;
    assign unused_ok = ^{ir_q[31:12], ir_q[6:0], ea_ld[2:0], ea_st[2:0]};

    function automatic logic [63:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[5:0];
            3'b010:  r = {63'd0, $signed(a) < $signed(b)};
            3'b011:  r = {63'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101: begin
                if (alt) r = $signed(a) >>> b[5:0];
                else     r = a >> b[5:0];
            end
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        imm_ok = 1'b1;
        if (funct3 == 3'b001)
            imm_ok = (instr[31:26] == 6'b000000);
        else if (funct3 == 3'b101)
            imm_ok = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
        alt_i = (funct3 == 3'b101) && instr[30];
        r_ok  = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
            3'b000:  take = (rs1_val == rs2_val);
            3'b001:  take = (rs1_val != rs2_val);
            3'b100:  take = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  take = (rs1_val <  rs2_val);
            3'b111:  take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        reg_we    = 1'b0;
        reg_wa    = instr[11:7];
        reg_wd    = 64'd0;
        o_pm_cs   = 1'b0;
        o_dm_cs   = 1'b0;
        o_dm_rw   = 1'b0;
        o_dm_addr = 64'd0;
        o_dm_data = 64'd0;
        case (state_q)
            S_FETCH: begin
                o_pm_cs = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ir_d    = instr;
                state_d = S_FETCH;
                pc_d    = pc_q + 64'd4;
                case (opcode)
                    OPC_OPIMM: if (imm_ok) begin
                        reg_we = 1'b1;
                        reg_wd = alu(funct3, alt_i, rs1_val, imm_i);
                    end
                    OPC_OP: if (r_ok) begin
                        reg_we = 1'b1;
                        reg_wd = alu(funct3, funct7[5], rs1_val, rs2_val);
                    end
                    OPC_LUI: begin
                        reg_we = 1'b1;
                        reg_wd = imm_u;
                    end
                    OPC_AUIPC: begin
                        reg_we = 1'b1;
                        reg_wd = pc_q + imm_u;
                    end
                    OPC_JAL: begin
                        reg_we = 1'b1;
                        reg_wd = pc_q + 64'd4;
                        pc_d   = pc_q + imm_j;
                    end
                    OPC_JALR: if (funct3 == 3'b000) begin
                        reg_we = 1'b1;
                        reg_wd = pc_q + 64'd4;
                        pc_d   = ea_ld & ~64'd1;
                    end
                    OPC_BRANCH: if (take) pc_d = pc_q + imm_b;
                    OPC_LOAD: if (funct3 == 3'b011) begin
                        o_dm_cs   = 1'b1;
                        o_dm_addr = {3'b000, ea_ld[63:3]};
                        pc_d      = pc_q;
                        state_d   = S_LOAD;
                    end
                    OPC_STORE: if (funct3 == 3'b011) begin
                        o_dm_cs   = 1'b1;
                        o_dm_rw   = 1'b1;
                        o_dm_addr = {3'b000, ea_st[63:3]};
                        o_dm_data = rs2_val;
                    end
                    default: ;
                endcase
            end
            S_LOAD: begin
                reg_we  = 1'b1;
                reg_wa  = ir_q[11:7];
                reg_wd  = i_dm_data;
                pc_d    = pc_q + 64'd4;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_FETCH;
            pc_q    <= 64'd0;
            ir_q    <= 32'd0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (reg_we && (reg_wa != 5'd0)) regs_q[reg_wa] <= reg_wd;
        end
    end
endmodule

// File: tb/tb_rv64_multicycle_core.sv
// Directed bench: small hand-assembled programs, results observed through
// store traffic and the fetch-address trace.
module tb_rv64_multicycle_core;
    logic        i_clk, i_rst;
    logic [63:0] o_pm_addr;
    logic        o_pm_cs;
    logic [31:0] i_pm_data;
    logic [63:0] o_dm_addr;
    logic        o_dm_cs, o_dm_rw;
    logic [63:0] o_dm_data;
    logic [63:0] i_dm_data;

    rv64_multicycle_core dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_pm_addr(o_pm_addr), .o_pm_cs(o_pm_cs), .i_pm_data(i_pm_data),
        .o_dm_addr(o_dm_addr), .o_dm_cs(o_dm_cs), .o_dm_rw(o_dm_rw),
        .o_dm_data(o_dm_data), .i_dm_data(i_dm_data)
    );

    logic [31:0] pm [64];
    logic [63:0] dm [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    logic [63:0] st_addr_q [$];
    logic [63:0] st_data_q [$];
    logic [63:0] f_addr_q  [$];
    int          f_cyc_q   [$];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) begin
        if (o_pm_cs) i_pm_data <= pm[o_pm_addr[5:0]];
        if (o_dm_cs) begin
            if (o_dm_rw) dm[o_dm_addr[3:0]] <= o_dm_data;
            else         i_dm_data <= dm[o_dm_addr[3:0]];
        end
    end

    always @(posedge i_clk) begin
        if (i_rst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_pm_cs) begin
                f_addr_q.push_back(o_pm_addr);
                f_cyc_q.push_back(cyc);
            end
            if (o_dm_cs && o_dm_rw) begin
                st_addr_q.push_back(o_dm_addr);
                st_data_q.push_back(o_dm_data);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = imm[11:0];
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [19:0] im;
        im = imm20[19:0];
        return {im, 5'(rd), op};
    endfunction

    // Reset asserted mid-cycle so the asynchronous path is what gets checked.
    task automatic start_prog(input string name);
        i_rst = 1'b1;
        #1;
        check_eq({name, "_rst_pm_cs"},   64'(o_pm_cs), 64'd1);
        check_eq({name, "_rst_pm_addr"}, o_pm_addr,    64'd0);
        check_eq({name, "_rst_dm_cs"},   64'(o_dm_cs), 64'd0);
        check_eq({name, "_rst_dm_rw"},   64'(o_dm_rw), 64'd0);
        check_eq({name, "_rst_dm_addr"}, o_dm_addr,    64'd0);
        check_eq({name, "_rst_dm_data"}, o_dm_data,    64'd0);
        for (int i = 0; i < 64; i++) pm[i] = 32'h0000_0013;
        st_addr_q.delete();
        st_data_q.delete();
        f_addr_q.delete();
        f_cyc_q.delete();
    endtask

    task automatic run_prog(input int ncyc);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        repeat (ncyc) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_store(input string tag, input int idx,
                             input logic [63:0] addr, input logic [63:0] data);
        check_eq({tag, "_present"}, 64'(st_addr_q.size() > idx), 64'd1);
        if (st_addr_q.size() > idx) begin
            check_eq({tag, "_addr"}, st_addr_q[idx], addr);
            check_eq({tag, "_data"}, st_data_q[idx], data);
        end
    endtask

    task automatic chk_fetch(input string tag, input int idx, input logic [63:0] addr);
        check_eq({tag, "_present"}, 64'(f_addr_q.size() > idx), 64'd1);
        if (f_addr_q.size() > idx) check_eq({tag, "_addr"}, f_addr_q[idx], addr);
    endtask

    initial begin
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);

        // add/sub with a negative operand
        start_prog("arith");
        pm[0] = enc_i(5, 0, 0, 1, 7'h13);
        pm[1] = enc_i(-3, 0, 0, 2, 7'h13);
        pm[2] = enc_r(0, 2, 1, 0, 3);
        pm[3] = enc_r(32, 1, 2, 0, 4);
        pm[4] = enc_s(0, 3, 0);
        pm[5] = enc_s(8, 4, 0);
        pm[6] = enc_j(0, 0);
        run_prog(30);
        chk_fetch("arith_f0", 0, 64'd0);
        check_eq("arith_f1_cycle", 64'(f_cyc_q.size() > 1 ? f_cyc_q[1] : -1), 64'd2);
        chk_store("arith_x3", 0, 64'd0, 64'd2);
        chk_store("arith_x4", 1, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8);

        // store, load back, store the loaded value; LD costs 3 cycles
        start_prog("ldsd");
        pm[0] = enc_i(85, 0, 0, 1, 7'h13);
        pm[1] = enc_s(16, 1, 0);
        pm[2] = enc_i(16, 0, 3, 2, 7'h03);
        pm[3] = enc_s(24, 2, 0);
        pm[4] = enc_j(0, 0);
        run_prog(24);
        chk_store("ldsd_sd", 0, 64'd2, 64'h55);
        chk_store("ldsd_x2", 1, 64'd3, 64'h55);
        chk_fetch("ldsd_f3", 3, 64'd3);
        check_eq("ldsd_f3_cycle", 64'(f_cyc_q.size() > 3 ? f_cyc_q[3] : -1), 64'd7);

        // taken branch
        start_prog("bne_t");
        pm[0] = enc_i(1, 0, 0, 1, 7'h13);
        pm[1] = enc_b(8, 0, 1, 1);
        pm[2] = enc_j(0, 0);
        pm[3] = enc_j(0, 0);
        run_prog(10);
        chk_fetch("bne_t_f2", 2, 64'd3);

        // not-taken branch
        start_prog("bne_n");
        pm[0] = enc_i(0, 0, 0, 1, 7'h13);
        pm[1] = enc_b(8, 0, 1, 1);
        pm[2] = enc_j(0, 0);
        pm[3] = enc_j(0, 0);
        run_prog(10);
        chk_fetch("bne_n_f2", 2, 64'd2);

        // jal / jalr, including rd==rs1 and odd target
        start_prog("jump");
        pm[0] = enc_j(12, 1);
        pm[1] = enc_i(9, 1, 0, 1, 7'h67);
        pm[2] = enc_j(0, 0);
        pm[3] = enc_s(0, 1, 0);
        pm[4] = enc_i(0, 1, 0, 0, 7'h67);
        run_prog(24);
        chk_fetch("jump_f1", 1, 64'd3);
        chk_store("jump_x1a", 0, 64'd0, 64'd4);
        chk_fetch("jump_f3", 3, 64'd1);
        chk_store("jump_x1b", 1, 64'd0, 64'd8);
        chk_fetch("jump_f6", 6, 64'd2);

        // shifts, compares, lui/auipc, x0 immutability
        start_prog("shift");
        pm[0]  = enc_i(1, 0, 0, 5, 7'h13);
        pm[1]  = enc_i(63, 5, 1, 1, 7'h13);
        pm[2]  = enc_i(1028, 1, 5, 2, 7'h13);
        pm[3]  = enc_i(4, 1, 5, 3, 7'h13);
        pm[4]  = enc_i(7, 0, 0, 0, 7'h13);
        pm[5]  = enc_r(0, 5, 1, 2, 4);
        pm[6]  = enc_r(0, 1, 5, 3, 6);
        pm[7]  = enc_u(32'h80000, 7, 7'h37);
        pm[8]  = enc_u(1, 8, 7'h17);
        pm[9]  = enc_r(0, 3, 2, 7, 9);
        pm[10] = enc_s(0, 1, 0);
        pm[11] = enc_s(8, 2, 0);
        pm[12] = enc_s(16, 3, 0);
        pm[13] = enc_s(24, 0, 0);
        pm[14] = enc_s(32, 4, 0);
        pm[15] = enc_s(40, 6, 0);
        pm[16] = enc_s(48, 7, 0);
        pm[17] = enc_s(56, 8, 0);
        pm[18] = enc_s(64, 9, 0);
        pm[19] = enc_j(0, 0);
        run_prog(50);
        chk_store("slli",  0, 64'd0, 64'h8000_0000_0000_0000);
        chk_store("srai",  1, 64'd1, 64'hF800_0000_0000_0000);
        chk_store("srli",  2, 64'd2, 64'h0800_0000_0000_0000);
        chk_store("x0",    3, 64'd3, 64'd0);
        chk_store("slt",   4, 64'd4, 64'd1);
        chk_store("sltu",  5, 64'd5, 64'd1);
        chk_store("lui",   6, 64'd6, 64'hFFFF_FFFF_8000_0000);
        chk_store("auipc", 7, 64'd7, 64'h0000_0000_0000_1020);
        chk_store("and",   8, 64'd8, 64'h0800_0000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv64_multicycle_core.md
# rv64_multicycle_core

Multi-cycle 64-bit RISC-V (RV64I subset) processor core with separate program-memory and data-memory ports. It fetches 32-bit instructions from a word-addressed program SRAM and performs 64-bit doubleword loads/stores on a doubleword-addressed data SRAM. Both memories are external single-port synchronous SRAMs with a 1-cycle read latency. The core is the only bus master in the processor top level.

## Interface
- Parameters: none.
- `i_clk` input 1: the only clock; all state updates on its rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `o_pm_addr` output 64: program-memory word index, equal to `{2'b0, PC[63:2]}`.
- `o_pm_cs` output 1: program-memory read strobe.
- `i_pm_data` input 32: instruction word, valid the cycle after the `o_pm_cs` cycle.
- `o_dm_addr` output 64: data-memory doubleword index, equal to `{3'b0, EA[63:3]}`.
- `o_dm_cs` output 1: data-memory access strobe.
- `o_dm_rw` output 1: 1 = write, 0 = read. Meaningful only while `o_dm_cs` = 1.
- `o_dm_data` output 64: store data (rs2).
- `i_dm_data` input 64: load data, valid the cycle after a read strobe.

## Operation
- Memory contract:
  - On a rising edge with cs=1 and rw/we=0, the SRAM registers `mem[addr]` onto its output.
  - With cs=1 and we=1, it writes `mem[addr]` and leaves its output unchanged.
  - With cs=0, its output holds.
  - The program SRAM is preloaded from a hex file.
- State: PC (64 bits), x0..x31 (64 bits each; x0 reads 0 and writes to it are discarded), instruction register IR, FSM.
- FSM states: FETCH, EXEC, LOAD.
  - FETCH: `o_pm_cs`=1 and `o_pm_addr` is derived from PC. Next state is EXEC.
  - EXEC: decode `i_pm_data` and latch it into IR.
    - ALU, LUI, AUIPC, branch and jump instructions: write rd, update PC, go to FETCH.
    - SD: `o_dm_cs`=1, `o_dm_rw`=1, `o_dm_data`=rs2, address from EA=rs1+sext(imm). PC+=4, go to FETCH.
    - LD: `o_dm_cs`=1, `o_dm_rw`=0, address from EA. Go to LOAD.
  - LOAD: rd ← `i_dm_data`, PC+=4, go to FETCH.
- Supported instructions:
  - ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI (6-bit shamt).
  - LUI, AUIPC.
  - LD, SD.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - JAL, JALR.
- All arithmetic is 64-bit two's complement and wraps silently. Immediates are sign-extended per RV64I; the LUI/AUIPC immediate is sign-extended from bit 31.
- Register-shift amounts use rs2[5:0].
- SLT and SLTI compare signed; SLTU and SLTIU compare unsigned.
- Branch taken: PC ← PC+sext(imm). Not taken: PC ← PC+4.
- JAL: rd ← PC+4, PC ← PC+imm.
- JALR: rd ← PC+4, PC ← (rs1+imm) with bit 0 cleared. rs1 is read before rd is written, so rd==rs1 works.
- All other opcodes execute as a NOP: PC+=4, no register or memory side effect. This covers *W ops, other load/store widths, FENCE, ECALL and EBREAK.
- Misalignment raises no exception:
  - Low EA bits [2:0] are ignored for data accesses.
  - PC bits [1:0] are ignored for fetch.
- `o_dm_cs`, `o_dm_rw`, `o_dm_addr` and `o_dm_data` are 0 in every state or instruction not listed above.
- `o_pm_cs` is 0 outside FETCH. `o_pm_addr` always reflects PC.

## Timing
- Reset (asynchronous, immediate effect): PC=0, all registers 0, IR=0, state=FETCH.
  - Outputs during and just after reset: `o_pm_cs`=1, `o_pm_addr`=0, `o_dm_cs`=0, `o_dm_rw`=0, `o_dm_addr`=0, `o_dm_data`=0.
- First fetch happens on the first rising edge after `i_rst` deasserts.
- Cycles per instruction: 2 for everything except LD, which takes 3.
- Register writes take effect at the end of EXEC or LOAD, so the next instruction sees the result. No forwarding hazards exist.
- A store is committed by the SRAM on the rising edge that ends EXEC.
- Reset asserted mid-instruction aborts it: no partial register write after reset. A store write that already reached the SRAM is not undone.

## Test plan
- Reset → `o_pm_addr`=0, `o_pm_cs`=1, `o_dm_cs`=0. Outputs of the first instruction appear 2 cycles after reset release.
- `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1` → x3=2, x4=0xFFFF_FFFF_FFFF_FFF8.
- `addi x1,x0,0x55; sd x1,16(x0); ld x2,16(x0)`:
  - During the SD EXEC cycle: `o_dm_addr`=2, `o_dm_rw`=1, `o_dm_data`=0x55.
  - At the end: x2=0x55. The LD takes 3 cycles.
- `addi x1,x0,1; bne x1,x0,+8` → next fetch `o_pm_addr`=3. With x1=0 instead, next fetch `o_pm_addr`=2.
- `jal x1,+12` at PC 0 → x1=4, next fetch `o_pm_addr`=3. Then `jalr x0,0(x1)` → PC=4.
- `slli x1,x5,63`, `srai`/`srli` on 0x8000_0000_0000_0000 → sign fill vs zero fill. `addi x0,x0,7` → x0 stays 0.
